stage_decode_pipe: RTL and testbench
====================================

# stage_decode_pipe

Parametrised, registered decode stage for the Osiris pipeline. It decodes the instruction, extends its immediate and reads a configurable register file (RV32E or RV32I). The results are captured in an ID/EX pipeline register with a valid/ready handshake. Internal load-use hazard detection stalls fetch and inserts bubbles, and a flush input kills wrong-path instructions. It sits between the IF/ID register and the execute stage.

## Interface
Parameters:
- XLEN, 32, data/PC width
- NUM_REGS, 16, architectural registers; only 16 or 32 are legal
- INDEX_WIDTH, 4, register index width; must equal log2(NUM_REGS)

Ports:
- clk  in  1  clock, rising edge
- i_rst_ID  in  1  synchronous, active-high reset
- i_valid_IF  in  1  instruction on i_instr_ID/i_pc_ID is valid
- o_ready_ID  out  1  stage accepts the instruction this cycle
- i_instr_ID  in  32  instruction word
- i_pc_ID  in  XLEN  instruction PC
- i_imm_src_ID  in  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U; other codes give 0
- i_flush_ID  in  1  kill the ID instruction and the ID/EX content
- i_ready_EX  in  1  execute stage consumes o_valid_EX data
- i_write_en_WB  in  1  register write enable
- i_rd_WB  in  INDEX_WIDTH  write index
- i_data_WB  in  XLEN  write data
- o_valid_EX  out  1  ID/EX entry valid
- o_op_EX  out  5  instr[6:2]
- o_funct3_EX  out  3  instr[14:12]
- o_funct_7_5_EX  out  1  instr[30]
- o_rd_EX, o_rs1Addr_EX, o_rs2Addr_EX  out  INDEX_WIDTH each  instr[7+:IW], instr[15+:IW], instr[20+:IW]
- o_rs1_EX, o_rs2_EX  out  XLEN each  operand values
- o_imm_ex_EX  out  XLEN  sign-extended immediate
- o_pc_EX  out  XLEN  registered PC
- o_stall_ID  out  1  load-use hazard this cycle

## Operation
- Register file:
  - x0 reads 0; writes to index 0 are ignored.
  - Write on the rising edge when i_write_en_WB is high.
  - Reads are combinational from the instruction's rs1/rs2 fields.
  - Reset clears all registers to 0.
- Hazard: hazard = o_valid_EX & (o_op_EX == 5'b00000) & (o_rd_EX != 0) & i_valid_IF & (o_rd_EX == rs1 | o_rd_EX == rs2). Both rs fields are compared, whatever the instruction format (conservative).
- o_stall_ID = hazard & ~i_flush_ID.
- o_ready_ID = (~o_valid_EX | i_ready_EX) & ~hazard & ~i_flush_ID.
- Per-edge priority for the ID/EX register:
  - reset: all outputs 0.
  - i_flush_ID: o_valid_EX <= 0; the incoming instruction is dropped.
  - o_valid_EX & ~i_ready_EX: hold all ID/EX fields.
  - hazard: o_valid_EX <= 0 (bubble); payload don't-care.
  - otherwise: load all fields, o_valid_EX <= i_valid_IF.
- Immediate formats follow RV32 I/S/B/J/U: bit 31 is the sign, the B/J LSB is 0, U has the low 12 bits at 0.
- Register indices use only the low INDEX_WIDTH bits of each field. With NUM_REGS=16, field bit 4 is ignored; no illegal-instruction check.

## Timing
- Latency: accepted on edge N, visible on o_*_EX after edge N.
- o_ready_ID, o_stall_ID and the operand reads are combinational.
- The load-use stall lasts exactly 1 cycle when i_ready_EX=1, because the bubble clears the hazard.
- The register write is visible to reads from the cycle after the write edge. A same-cycle read is covered under Configuration.
- Reset mid-stream: the next cycle has o_valid_EX=0 and all registers 0. Reset overrides flush and WB writes in that cycle.

## Configuration
- STAGE_DECODE_WB_BYPASS_EN defined: a read whose index equals i_rd_WB (nonzero) while i_write_en_WB=1 returns i_data_WB in the same cycle.
- Undefined: such a read returns the old register value. The pipeline must then guarantee a one-cycle WB-to-ID gap.

## Structure
- Shared package osiris_pkg:
  - immediate-source codes (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U)
  - opcode constant OP_LOAD = 5'b00000
  - legal NUM_REGS values
- Sub-module decode_regfile (parameters XLEN, NUM_REGS, INDEX_WIDTH): 2 read ports, 1 write port, synchronous reset, holds the bypass logic.
- Immediate extension and hazard logic are inline.

## Test plan
- Write x5=0xDEADBEEF, then issue `add x1,x5,x0` (0x000280B3) with i_ready_EX=1 → one cycle later o_valid_EX=1, o_rs1_EX=0xDEADBEEF, o_rs2_EX=0, o_rd_EX=1.
- `lw x6,4(x2)` accepted, then `add x7,x6,x6` presented → o_stall_ID=1 and o_ready_ID=0 for 1 cycle, one bubble (o_valid_EX=0), then the add is accepted.
- i_ready_EX=0 for 3 cycles with valid EX content → ID/EX fields constant, o_ready_ID=0; on release the next instruction is accepted the same cycle.
- Flush while stalled → next cycle o_valid_EX=0, o_stall_ID=0; the stalled instruction is never delivered.
- imm_src=010, instr 0xFE000EE3 (beq x0,x0,-4) → o_imm_ex_EX=0xFFFFFFFC. imm_src=100, instr 0x12345037 → 0x12345000.
- With the macro: same-cycle WB x3=0x55 plus a read of x3 → 0x55. Without it → old value. A write to x0 always reads 0. NUM_REGS=32 reaches x31 and NUM_REGS=16 aliases x21 to x5.

Source files
------------

// File: rtl/osiris_pkg.sv
// rtl/osiris_pkg.sv - shared constants for the Osiris decode stage
package osiris_pkg;

    // Immediate-source select codes; any other code yields a zero immediate.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // instr[6:2] of a load; the only producer that can cause a load-use stall.
    localparam logic [4:0] OP_LOAD = 5'b00000;

    // Legal register-file depths: RV32E and RV32I.
    localparam int NUM_REGS_RV32E = 16;
    localparam int NUM_REGS_RV32I = 32;

    function automatic logic num_regs_legal(input int n);
        return (n == NUM_REGS_RV32E) || (n == NUM_REGS_RV32I);
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 2-read/1-write architectural register file
//
// Ports: clk, rst (sync, active-high, clears all registers),
//        write_en/wr_index/wr_data (write port, index 0 ignored),
//        rs1_index/rs2_index -> rs1_data/rs2_data (combinational reads, x0 = 0).
// Option: STAGE_DECODE_WB_BYPASS_EN forwards a same-cycle write to the reads.
module decode_regfile
    import osiris_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = NUM_REGS_RV32E,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [INDEX_WIDTH-1:0] rs1_index,
    input  logic [INDEX_WIDTH-1:0] rs2_index,
    output logic [XLEN-1:0]        rs1_data,
    output logic [XLEN-1:0]        rs2_data
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (wr_index != '0)) begin
            regs[wr_index] <= wr_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [INDEX_WIDTH-1:0] idx);
        logic [XLEN-1:0] value;
        value = (idx == '0) ? '0 : regs[idx];
`ifdef STAGE_DECODE_WB_BYPASS_EN
        // Forward the writeback in flight so WB and ID may overlap.
        if (write_en && (wr_index != '0) && (wr_index == idx)) begin
            value = wr_data;
        end
`endif
        return value;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_index);
        rs2_data = read_port(rs2_index);
    end

endmodule

// File: rtl/stage_decode_pipe.sv
// rtl/stage_decode_pipe.sv - Osiris decode stage with registered ID/EX output
//
// Ports: clk, i_rst_ID (sync, active-high); IF side i_valid_IF/o_ready_ID,
//        i_instr_ID, i_pc_ID, i_imm_src_ID; i_flush_ID kills ID and ID/EX;
//        EX side o_valid_EX/i_ready_EX plus decoded fields o_*_EX;
//        WB write port i_write_en_WB/i_rd_WB/i_data_WB; o_stall_ID load-use stall.
// Option: STAGE_DECODE_WB_BYPASS_EN (see decode_regfile).
module stage_decode_pipe
    import osiris_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 16,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   i_rst_ID,
    input  logic                   i_valid_IF,
    output logic                   o_ready_ID,
    input  logic [31:0]            i_instr_ID,
    input  logic [XLEN-1:0]        i_pc_ID,
    input  logic [2:0]             i_imm_src_ID,
    input  logic                   i_flush_ID,
    input  logic                   i_ready_EX,
    input  logic                   i_write_en_WB,
    input  logic [INDEX_WIDTH-1:0] i_rd_WB,
    input  logic [XLEN-1:0]        i_data_WB,
    output logic                   o_valid_EX,
    output logic [4:0]             o_op_EX,
    output logic [2:0]             o_funct3_EX,
    output logic                   o_funct_7_5_EX,
    output logic [INDEX_WIDTH-1:0] o_rd_EX,
    output logic [INDEX_WIDTH-1:0] o_rs1Addr_EX,
    output logic [INDEX_WIDTH-1:0] o_rs2Addr_EX,
    output logic [XLEN-1:0]        o_rs1_EX,
    output logic [XLEN-1:0]        o_rs2_EX,
    output logic [XLEN-1:0]        o_imm_ex_EX,
    output logic [XLEN-1:0]        o_pc_EX,
    output logic                   o_stall_ID
);

    // Only the low INDEX_WIDTH bits of each field are used (RV32E aliases x16..x31).
    logic [INDEX_WIDTH-1:0] rd_idx, rs1_idx, rs2_idx;
    assign rd_idx  = i_instr_ID[7  +: INDEX_WIDTH];
    assign rs1_idx = i_instr_ID[15 +: INDEX_WIDTH];
    assign rs2_idx = i_instr_ID[20 +: INDEX_WIDTH];

    logic [XLEN-1:0] rs1_val, rs2_val;

    decode_regfile #(
        .XLEN        (XLEN),
        .NUM_REGS    (NUM_REGS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_regfile (
        .clk       (clk),
        .rst       (i_rst_ID),
        .write_en  (i_write_en_WB),
        .wr_index  (i_rd_WB),
        .wr_data   (i_data_WB),
        .rs1_index (rs1_idx),
        .rs2_index (rs2_idx),
        .rs1_data  (rs1_val),
        .rs2_data  (rs2_val)
    );

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm32 = '0;
        case (i_imm_src_ID)
            IMM_I: imm32 = {{20{i_instr_ID[31]}}, i_instr_ID[31:20]};
            IMM_S: imm32 = {{20{i_instr_ID[31]}}, i_instr_ID[31:25], i_instr_ID[11:7]};
            IMM_B: imm32 = {{19{i_instr_ID[31]}}, i_instr_ID[31], i_instr_ID[7],
                            i_instr_ID[30:25], i_instr_ID[11:8], 1'b0};
            IMM_J: imm32 = {{11{i_instr_ID[31]}}, i_instr_ID[31], i_instr_ID[19:12],
                            i_instr_ID[20], i_instr_ID[30:21], 1'b0};
            IMM_U: imm32 = {i_instr_ID[31:12], 12'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // Load-use: both rs fields are compared regardless of format, which can
    // stall needlessly on formats without rs2 but never misses a real hazard.
    logic hazard;
    assign hazard = o_valid_EX && (o_op_EX == OP_LOAD) && (o_rd_EX != '0) && i_valid_IF &&
                    ((o_rd_EX == rs1_idx) || (o_rd_EX == rs2_idx));

    assign o_stall_ID = hazard && !i_flush_ID;
    assign o_ready_ID = (!o_valid_EX || i_ready_EX) && !hazard && !i_flush_ID;

    always_ff @(posedge clk) begin
        if (i_rst_ID) begin
            o_valid_EX     <= 1'b0;
            o_op_EX        <= '0;
            o_funct3_EX    <= '0;
            o_funct_7_5_EX <= 1'b0;
            o_rd_EX        <= '0;
            o_rs1Addr_EX   <= '0;
            o_rs2Addr_EX   <= '0;
            o_rs1_EX       <= '0;
            o_rs2_EX       <= '0;
            o_imm_ex_EX    <= '0;
            o_pc_EX        <= '0;
        end else if (i_flush_ID) begin
            o_valid_EX <= 1'b0;
        end else if (o_valid_EX && !i_ready_EX) begin
            // EX back-pressure: every ID/EX field holds.
            o_valid_EX <= o_valid_EX;
        end else if (hazard) begin
            o_valid_EX <= 1'b0;
        end else begin
            o_valid_EX     <= i_valid_IF;
            o_op_EX        <= i_instr_ID[6:2];
            o_funct3_EX    <= i_instr_ID[14:12];
            o_funct_7_5_EX <= i_instr_ID[30];
            o_rd_EX        <= rd_idx;
            o_rs1Addr_EX   <= rs1_idx;
            o_rs2Addr_EX   <= rs2_idx;
            o_rs1_EX       <= rs1_val;
            o_rs2_EX       <= rs2_val;
            o_imm_ex_EX    <= imm_ext;
            o_pc_EX        <= i_pc_ID;
        end
    end

endmodule

// File: tb/tb_stage_decode_pipe.sv
// tb/tb_stage_decode_pipe.sv - self-checking bench for stage_decode_pipe
module tb_stage_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, valid_if, flush, ready_ex, we, valid2;
    logic [31:0] instr, pc, data_wb;
    logic [2:0]  imm_src;
    logic [4:0]  rd_wb;

    logic        ready16, valid16, f75_16, stall16;
    logic [4:0]  op16;
    logic [2:0]  f3_16;
    logic [3:0]  rd16, rs1a16, rs2a16;
    logic [31:0] rs1v16, rs2v16, imm16, pc16;

    logic        ready32, valid32, f75_32, stall32;
    logic [4:0]  op32;
    logic [2:0]  f3_32;
    logic [4:0]  rd32, rs1a32, rs2a32;
    logic [31:0] rs1v32, rs2v32, imm32, pc32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage_decode_pipe #(.XLEN(32), .NUM_REGS(16), .INDEX_WIDTH(4)) dut16 (
        .clk(clk), .i_rst_ID(rst), .i_valid_IF(valid_if), .o_ready_ID(ready16),
        .i_instr_ID(instr), .i_pc_ID(pc), .i_imm_src_ID(imm_src), .i_flush_ID(flush),
        .i_ready_EX(ready_ex), .i_write_en_WB(we), .i_rd_WB(rd_wb[3:0]), .i_data_WB(data_wb),
        .o_valid_EX(valid16), .o_op_EX(op16), .o_funct3_EX(f3_16), .o_funct_7_5_EX(f75_16),
        .o_rd_EX(rd16), .o_rs1Addr_EX(rs1a16), .o_rs2Addr_EX(rs2a16),
        .o_rs1_EX(rs1v16), .o_rs2_EX(rs2v16), .o_imm_ex_EX(imm16), .o_pc_EX(pc16),
        .o_stall_ID(stall16)
    );

    stage_decode_pipe #(.XLEN(32), .NUM_REGS(32), .INDEX_WIDTH(5)) dut32 (
        .clk(clk), .i_rst_ID(rst), .i_valid_IF(valid2), .o_ready_ID(ready32),
        .i_instr_ID(instr), .i_pc_ID(pc), .i_imm_src_ID(imm_src), .i_flush_ID(flush),
        .i_ready_EX(ready_ex), .i_write_en_WB(we), .i_rd_WB(rd_wb), .i_data_WB(data_wb),
        .o_valid_EX(valid32), .o_op_EX(op32), .o_funct3_EX(f3_32), .o_funct_7_5_EX(f75_32),
        .o_rd_EX(rd32), .o_rs1Addr_EX(rs1a32), .o_rs2Addr_EX(rs2a32),
        .o_rs1_EX(rs1v32), .o_rs2_EX(rs2v32), .o_imm_ex_EX(imm32), .o_pc_EX(pc32),
        .o_stall_ID(stall32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Immediate value as a signed number assembled from its scattered fields.
    function automatic logic [31:0] model_imm(input logic [31:0] w, input logic [2:0] src);
        longint u;
        int     nbits;
        case (src)
            3'd0: begin u = longint'(w[31:20]); nbits = 12; end
            3'd1: begin u = longint'(w[31:25]) * 32 + longint'(w[11:7]); nbits = 12; end
            3'd2: begin
                u = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                    longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                nbits = 13;
            end
            3'd3: begin
                u = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                    longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                nbits = 21;
            end
            3'd4: return {w[31:12], 12'h000};
            default: return 32'h0;
        endcase
        if (u >= (64'sd1 << (nbits - 1))) u = u - (64'sd1 << nbits);
        return u[31:0];
    endfunction

    // Reference state for the 16-register instance
    logic [31:0] mreg [16];
    logic        mv;
    logic [4:0]  mop;
    logic [2:0]  mf3;
    logic        mf7;
    logic [3:0]  mrd, mrs1a, mrs2a;
    logic [31:0] mrs1v, mrs2v, mimm, mpc;

    function automatic logic [31:0] model_read(input logic [3:0] idx);
        if (idx == 4'd0) return 32'h0;
`ifdef STAGE_DECODE_WB_BYPASS_EN
        if (we && rd_wb[3:0] == idx) return data_wb;
`endif
        return mreg[idx];
    endfunction

    task automatic idle();
        rst = 0; valid_if = 0; flush = 0; ready_ex = 1; we = 0; valid2 = 0;
        rd_wb = 0; data_wb = 0; instr = 0; pc = 0; imm_src = 0;
    endtask

    logic        hz, exp_ready, exp_stall;
    logic [31:0] rnd;

    initial begin
        idle();
        // Reset state
        rst = 1;
        tick(); tick();
        chk("rst_valid", {31'b0, valid16}, 32'h0);
        chk("rst_op", {27'b0, op16}, 32'h0);
        chk("rst_rd", {28'b0, rd16}, 32'h0);
        chk("rst_rs1", rs1v16, 32'h0);
        chk("rst_imm", imm16, 32'h0);
        chk("rst_pc", pc16, 32'h0);
        rst = 0;
        #1;
        chk("rst_ready", {31'b0, ready16}, 32'h1);
        chk("rst_stall", {31'b0, stall16}, 32'h0);

        // Write x5, then read it through add x1,x5,x0
        we = 1; rd_wb = 5; data_wb = 32'hDEADBEEF;
        tick();
        we = 0; valid_if = 1; instr = 32'h000280B3; pc = 32'h100;
        tick();
        chk("add_valid", {31'b0, valid16}, 32'h1);
        chk("add_rs1", rs1v16, 32'hDEADBEEF);
        chk("add_rs2", rs2v16, 32'h0);
        chk("add_rd", {28'b0, rd16}, 32'h1);
        chk("add_pc", pc16, 32'h100);

        // Load-use: lw x6,4(x2) then add x7,x6,x6
        instr = 32'h00412303;
        tick();
        chk("lw_op", {27'b0, op16}, 32'h0);
        chk("lw_rd", {28'b0, rd16}, 32'h6);
        chk("lw_imm", imm16, 32'h4);
        instr = 32'h006303B3;
        #1;
        chk("lu_stall", {31'b0, stall16}, 32'h1);
        chk("lu_ready", {31'b0, ready16}, 32'h0);
        tick();
        chk("lu_bubble", {31'b0, valid16}, 32'h0);
        chk("lu_stall_clear", {31'b0, stall16}, 32'h0);
        chk("lu_ready_back", {31'b0, ready16}, 32'h1);
        tick();
        chk("lu_add_valid", {31'b0, valid16}, 32'h1);
        chk("lu_add_rd", {28'b0, rd16}, 32'h7);

        // EX back-pressure for 3 cycles
        ready_ex = 0; instr = 32'h00108433;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'b0, ready16}, 32'h0);
            tick();
            chk("bp_hold_rd", {28'b0, rd16}, 32'h7);
            chk("bp_hold_valid", {31'b0, valid16}, 32'h1);
        end
        ready_ex = 1;
        #1;
        chk("bp_release_ready", {31'b0, ready16}, 32'h1);
        tick();
        chk("bp_release_rd", {28'b0, rd16}, 32'h8);

        // Flush while stalled
        instr = 32'h00412303;
        tick();
        chk("fl_lw_rd", {28'b0, rd16}, 32'h6);
        instr = 32'h006303B3;
        #1;
        chk("fl_pre_stall", {31'b0, stall16}, 32'h1);
        flush = 1;
        #1;
        chk("fl_stall", {31'b0, stall16}, 32'h0);
        chk("fl_ready", {31'b0, ready16}, 32'h0);
        tick();
        chk("fl_valid", {31'b0, valid16}, 32'h0);
        flush = 0; valid_if = 0;
        tick();
        chk("fl_never_delivered", {31'b0, valid16}, 32'h0);

        // Immediate formats
        valid_if = 1;
        imm_src = 3'b010; instr = 32'hFE000EE3;
        tick();
        chk("imm_b", imm16, 32'hFFFFFFFC);
        imm_src = 3'b100; instr = 32'h12345037;
        tick();
        chk("imm_u", imm16, 32'h12345000);
        imm_src = 3'b001; instr = 32'hFE512C23;
        tick();
        chk("imm_s", imm16, 32'hFFFFFFF8);
        imm_src = 3'b011; instr = 32'hFFDFF0EF;
        tick();
        chk("imm_j", imm16, 32'hFFFFFFFC);
        imm_src = 3'b111;
        tick();
        chk("imm_bad", imm16, 32'h0);
        imm_src = 3'b000;

        // Same-cycle WB of x3 while reading it
        valid_if = 0; we = 1; rd_wb = 3; data_wb = 32'h11;
        tick();
        data_wb = 32'h55; valid_if = 1; instr = 32'h000184B3;
        tick();
        we = 0;
`ifdef STAGE_DECODE_WB_BYPASS_EN
        chk("wb_same_cycle", rs1v16, 32'h55);
`else
        chk("wb_same_cycle", rs1v16, 32'h11);
`endif
        tick();
        chk("wb_next_cycle", rs1v16, 32'h55);

        // Writes to x0 are ignored
        valid_if = 0; we = 1; rd_wb = 0; data_wb = 32'h1234;
        tick();
        we = 0; valid_if = 1; instr = 32'h00000533;
        tick();
        chk("x0_read", rs1v16, 32'h0);

        // Index aliasing: RV32E maps x21->x5 and x31->x15
        valid_if = 0; we = 1; rd_wb = 21; data_wb = 32'h0000A5A5;
        tick();
        rd_wb = 31; data_wb = 32'h00003131;
        tick();
        we = 0; valid_if = 1; valid2 = 1; instr = 32'h005A80B3;
        tick();
        chk("e_x21_rs1", rs1v16, 32'h0000A5A5);
        chk("e_x5_rs2", rs2v16, 32'h0000A5A5);
        chk("i_x21_rs1", rs1v32, 32'h0000A5A5);
        chk("i_x5_rs2", rs2v32, 32'hDEADBEEF);
        instr = 32'h00FF80B3;
        tick();
        chk("i_x31_rs1", rs1v32, 32'h00003131);
        chk("i_x15_rs2", rs2v32, 32'h0);
        chk("i_x31_addr", {27'b0, rs1a32}, 32'd31);
        chk("e_x31_rs1", rs1v16, 32'h00003131);
        chk("e_x31_addr", {28'b0, rs1a16}, 32'd15);
        valid2 = 0;

        // Randomized run against the reference model
        idle();
        rst = 1;
        tick();
        mv = 0; mop = 0; mf3 = 0; mf7 = 0; mrd = 0; mrs1a = 0; mrs2a = 0;
        mrs1v = 0; mrs2v = 0; mimm = 0; mpc = 0;
        for (int i = 0; i < 16; i++) mreg[i] = 32'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            valid_if = ($urandom_range(0, 3) != 0);
            ready_ex = ($urandom_range(0, 2) != 0);
            rnd = $urandom;
            if ($urandom_range(0, 2) == 0) rnd[6:0] = 7'b0000011;
            else rnd[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) begin
                rnd[11:7]  = 5'($urandom_range(0, 5));
                rnd[19:15] = 5'($urandom_range(0, 5));
                rnd[24:20] = 5'($urandom_range(0, 5));
            end
            instr   = rnd;
            pc      = $urandom;
            imm_src = 3'($urandom_range(0, 7));
            we      = ($urandom_range(0, 1) == 1);
            rd_wb   = 5'($urandom_range(0, 31));
            data_wb = $urandom;
            #1;

            hz = mv && (mop == 5'd0) && (mrd != 4'd0) && valid_if &&
                 ((mrd == instr[18:15]) || (mrd == instr[23:20]));
            exp_ready = (!mv || ready_ex) && !hz && !flush;
            exp_stall = hz && !flush;
            chk("rnd_ready", {31'b0, ready16}, {31'b0, exp_ready});
            chk("rnd_stall", {31'b0, stall16}, {31'b0, exp_stall});

            if (rst) begin
                mv = 0; mop = 0; mf3 = 0; mf7 = 0; mrd = 0; mrs1a = 0; mrs2a = 0;
                mrs1v = 0; mrs2v = 0; mimm = 0; mpc = 0;
                for (int i = 0; i < 16; i++) mreg[i] = 32'h0;
            end else begin
                if (flush) begin
                    mv = 0;
                end else if (mv && !ready_ex) begin
                    mv = mv;
                end else if (hz) begin
                    mv = 0;
                end else begin
                    mv    = valid_if;
                    mop   = instr[6:2];
                    mf3   = instr[14:12];
                    mf7   = instr[30];
                    mrd   = instr[10:7];
                    mrs1a = instr[18:15];
                    mrs2a = instr[23:20];
                    mrs1v = model_read(instr[18:15]);
                    mrs2v = model_read(instr[23:20]);
                    mimm  = model_imm(instr, imm_src);
                    mpc   = pc;
                end
                if (we && rd_wb[3:0] != 4'd0) mreg[rd_wb[3:0]] = data_wb;
            end

            tick();
            chk("rnd_valid", {31'b0, valid16}, {31'b0, mv});
            if (mv || rst) begin
                chk("rnd_op", {27'b0, op16}, {27'b0, mop});
                chk("rnd_f3", {29'b0, f3_16}, {29'b0, mf3});
                chk("rnd_f7", {31'b0, f75_16}, {31'b0, mf7});
                chk("rnd_rd", {28'b0, rd16}, {28'b0, mrd});
                chk("rnd_rs1a", {28'b0, rs1a16}, {28'b0, mrs1a});
                chk("rnd_rs2a", {28'b0, rs2a16}, {28'b0, mrs2a});
                chk("rnd_rs1", rs1v16, mrs1v);
                chk("rnd_rs2", rs2v16, mrs2v);
                chk("rnd_imm", imm16, mimm);
                chk("rnd_pc", pc16, mpc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
